// File: rtl/instr_encoder_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_encoder_loader: encodes symbolic RV32I requests, writes imem words |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_kind,
    input  logic [2:0]        i_funct3,
    input  logic              i_funct7b5,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rs1,
    input  logic [4:0]        i_rs2,
    input  logic [31:0]       i_imm,
    input  logic              i_done,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_err,
    output logic              o_loaded
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_SW   = 7'b0100011;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                err_q, err_d;
    logic                loaded_q, loaded_d;
    logic                done_pend_q, done_pend_d;

    logic                fits12, fits13, fits21, imm_even, shamt_ok, is_shift;
    logic                enc_legal;
    logic [31:0]         enc_word;
    logic [ADDR_W:0]     count_inc;

    // Immediate range checks: upper bits must all replicate the sign bit.
    always_comb begin
        fits12   = (i_imm[31:11] == {21{i_imm[31]}});
        fits13   = (i_imm[31:12] == {20{i_imm[31]}});
        fits21   = (i_imm[31:20] == {12{i_imm[31]}});
        imm_even = ~i_imm[0];
        shamt_ok = (i_imm[31:5] == 27'd0);
        is_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
    end

    always_comb begin
        enc_legal = 1'b1;
        enc_word  = 32'd0;
        case (i_kind)
            3'd0: enc_word = {1'b0, i_funct7b5, 5'b0, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
            3'd1: begin
                if (is_shift) begin
                    enc_legal = shamt_ok;
                    enc_word  = {1'b0, i_funct7b5, 5'b0, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_IALU};
                end else begin
                    enc_legal = fits12;
                    enc_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_IALU};
                end
            end
            3'd2: begin
                enc_legal = fits12;
                enc_word  = {i_imm[11:0], i_rs1, 3'b010, i_rd, OP_LW};
            end
            3'd3: begin
                enc_legal = fits12;
                enc_word  = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
            end
            3'd4: begin
                enc_legal = fits13 & imm_even;
                enc_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], OP_BR};
            end
            3'd5: begin
                enc_legal = fits21 & imm_even;
                enc_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
            end
            3'd6: begin
                enc_legal = fits12;
                enc_word  = {i_imm[11:5], i_rs2, i_rs1, 3'b010, i_imm[4:0], OP_SW};
            end
            default: enc_legal = 1'b0;
        endcase
    end

    assign count_inc = count_q + (ADDR_W + 1)'(1);

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        full_d      = full_q;
        err_d       = err_q;
        loaded_d    = loaded_q;
        done_pend_d = done_pend_q;
        case (state_q)
            ST_READY: begin
                if (i_valid && ready_q && enc_legal) begin
                    state_d     = ST_WRITE;
                    ready_d     = 1'b0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = count_q[ADDR_W-1:0];
                    mem_wdata_d = enc_word;
                    done_pend_d = i_done;
                end else begin
                    if (i_valid && ready_q) begin
                        err_d = 1'b1;
                    end
                    if (i_done) begin
                        state_d  = ST_DONE;
                        ready_d  = 1'b0;
                        loaded_d = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                // The strobe is already on the port; commit the word count now.
                count_d     = count_inc;
                full_d      = (count_inc == CAPACITY);
                done_pend_d = 1'b0;
                if (done_pend_q || i_done) begin
                    state_d  = ST_DONE;
                    ready_d  = 1'b0;
                    loaded_d = 1'b1;
                end else begin
                    state_d = ST_READY;
                    ready_d = (count_inc != CAPACITY);
                end
            end
            default: begin
                state_d = ST_DONE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_READY;
            ready_q     <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            count_q     <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            loaded_q    <= 1'b0;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            full_q      <= full_d;
            err_q       <= err_d;
            loaded_q    <= loaded_d;
            done_pend_q <= done_pend_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_count     = count_q;
    assign o_full      = full_q;
    assign o_err       = err_q;
    assign o_loaded    = loaded_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_encoder_loader: scoreboard bench with a behavioural encoder     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_instr_encoder_loader;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [2:0]    i_kind = 3'd0;
    logic [2:0]    i_funct3 = 3'd0;
    logic          i_funct7b5 = 1'b0;
    logic [4:0]    i_rd = 5'd0, i_rs1 = 5'd0, i_rs2 = 5'd0;
    logic [31:0]   i_imm = 32'd0;
    logic          i_done = 1'b0;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [AW:0]   o_count;
    logic          o_full, o_err, o_loaded;

    int total = 0;
    int bad   = 0;

    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] mon_e;

    int  m_count;
    bit  m_full, m_err, m_loaded;

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_kind(i_kind), .i_funct3(i_funct3), .i_funct7b5(i_funct7b5),
        .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .i_done(i_done), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_count(o_count), .o_full(o_full),
        .o_err(o_err), .o_loaded(o_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe outside reset must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && o_mem_we) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h want no write", o_mem_addr, o_mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({o_mem_addr, o_mem_wdata} !== mon_e) begin
                    bad++;
                    $display("FAIL write: got addr=%0d data=%h want addr=%0d data=%h",
                             o_mem_addr, o_mem_wdata, mon_e[AW+31:32], mon_e[31:0]);
                end
            end
        end
    end

    // Reference encoder from the instruction-format rules, using integer arithmetic.
    function automatic void model_enc(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [31:0] imm, output bit ok, output logic [31:0] w);
        longint s;
        int unsigned lo, b, j, up;
        s  = $signed(imm);
        lo = imm & 32'hFFF;
        ok = 1'b1;
        w  = 32'd0;
        case (k)
            3'd0: w = 32'h33 | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                      | (32'(rs2) << 20) | (32'(f7) << 30);
            3'd1: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    ok = (s >= 0) && (s <= 31);
                    up = (f7 ? 32'd1024 : 32'd0) + (imm & 32'h1F);
                end else begin
                    ok = (s >= -2048) && (s <= 2047);
                    up = lo;
                end
                w = (up << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
            end
            3'd2, 3'd3: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = (lo << 20) | (32'(rs1) << 15) | (32'(rd) << 7)
                     | ((k == 3'd2) ? (32'd2 << 12) | 32'h03 : 32'h67);
            end
            3'd4: begin
                ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
                b  = imm & 32'h1FFF;
                w  = (((b >> 12) & 1) << 31) | (((b >> 5) & 63) << 25) | (32'(rs2) << 20)
                     | (32'(rs1) << 15) | (32'(f3) << 12) | (((b >> 1) & 15) << 8)
                     | (((b >> 11) & 1) << 7) | 32'h63;
            end
            3'd5: begin
                ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
                j  = imm & 32'h1FFFFF;
                w  = (((j >> 20) & 1) << 31) | (((j >> 1) & 1023) << 21) | (((j >> 11) & 1) << 20)
                     | (((j >> 12) & 255) << 12) | (32'(rd) << 7) | 32'h6F;
            end
            3'd6: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = ((lo >> 5) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'd2 << 12)
                     | ((lo & 31) << 7) | 32'h23;
            end
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_count"}, 64'(o_count), 64'(m_count));
        chk({tag, "_full"}, 64'(o_full), 64'(m_full));
        chk({tag, "_err"}, 64'(o_err), 64'(m_err));
        chk({tag, "_loaded"}, 64'(o_loaded), 64'(m_loaded));
        chk({tag, "_ready"}, 64'(o_ready), 64'(!(m_full || m_loaded)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        m_count = 0; m_full = 0; m_err = 0; m_loaded = 0;
        chk("rst_we", 64'(o_mem_we), 64'd0);
        chk("rst_addr", 64'(o_mem_addr), 64'd0);
        chk("rst_wdata", 64'(o_mem_wdata), 64'd0);
        check_state("rst");
        rst = 1'b0;
    endtask

    // dm: 0 no done, 1 done with the request, 2 done during the write cycle
    task automatic do_req(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input int dm);
        bit ok, acc;
        logic [31:0] w;
        model_enc(k, f3, f7, rd, rs1, rs2, imm, ok, w);
        acc = !m_full && !m_loaded;
        i_kind = k; i_funct3 = f3; i_funct7b5 = f7;
        i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
        i_valid = 1'b1;
        i_done = (dm == 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_done  = 1'b0;
        if (acc && ok) begin
            exp_q.push_back({AW'(m_count), w});
            chk("ready_low_in_write", 64'(o_ready), 64'd0);
            i_done = (dm == 2);
            @(posedge clk); #1;
            i_done = 1'b0;
            m_count++;
            m_full = (m_count == CAP);
            if (dm != 0) m_loaded = 1;
        end else begin
            if (acc) m_err = 1;
            if (dm == 1) m_loaded = 1;
        end
        chk("write_seen", 64'(exp_q.size()), 64'd0);
        check_state("req");
    endtask

    function automatic logic [31:0] rand_imm();
        int edges [0:22] = '{-2049, -2048, -4, -2, -1, 0, 1, 3, 4, 31, 32, 2047, 2048,
                             4094, 4095, 4096, -4096, -4097, 1048574, 1048575, 1048576,
                             -1048576, -1048578};
        case ($urandom_range(0, 2))
            0: return 32'(edges[$urandom_range(0, 22)]);
            1: return 32'(int'($urandom_range(0, 8191)) - 4096);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        do_req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 0);
        chk("add_word", 64'(o_mem_wdata), 64'h002081B3);

        do_reset();
        do_req(3'd6, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8, 0);
        chk("sw_word", 64'(o_mem_wdata), 64'h00512423);
        do_req(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4, 0);
        chk("beq_word", 64'(o_mem_wdata), 64'hFE208EE3);

        do_req(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 0);
        chk("jal_word", 64'(o_mem_wdata), 64'h001000EF);
        do_req(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 0);

        do_reset();
        do_req(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 0);
        do_req(3'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 0);
        do_req(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 0);
        chk("addi_word", 64'(o_mem_wdata), 64'h00500093);

        do_reset();
        for (int i = 0; i < CAP; i++) do_req(3'd0, 3'(i), 1'b1, 5'(i), 5'd7, 5'd9, 32'd0, 0);
        chk("full_flag", 64'(o_full), 64'd1);
        do_req(3'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0, 0);

        do_reset();
        do_req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1);
        do_req(3'd0, 3'd0, 1'b0, 5'd4, 5'd1, 5'd2, 32'd0, 0);

        do_reset();
        do_req(3'd2, 3'd0, 1'b0, 5'd4, 5'd1, 5'd0, -32'sd8, 2);

        do_reset();
        i_kind = 3'd0; i_rd = 5'd3; i_rs1 = 5'd1; i_rs2 = 5'd2; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        rst = 1'b1;
        do_reset();
        do_req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 0);

        for (int ep = 0; ep < 40; ep++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 6);
            for (int r = 0; r < n; r++) begin
                int sel, dm;
                sel = $urandom_range(0, 19);
                dm  = (sel == 0) ? 1 : ((sel == 1) ? 2 : 0);
                do_req(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       5'($urandom), 5'($urandom), 5'($urandom), rand_imm(), dm);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
